// File: rtl/ad7606_frame_tx.sv
// Drains one CH_NUM-word scan from the AD7606 sample FIFO and sends it to the UART
// as AA 55 + 16-bit words MSB first. Define FRAME_CHECKSUM_EN to append a sum byte.
module ad7606_frame_tx #(
    parameter int         CH_NUM = 8,
    parameter logic [7:0] HDR0   = 8'hAA,
    parameter logic [7:0] HDR1   = 8'h55
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  rdusedw,
    input  logic [15:0] ad_data,
    output logic        rdreq,
    output logic [7:0]  tx_data,
    output logic        send_en,
    input  logic        tx_done,
    output logic        busy_tx,
    output logic        frame_done
);

    localparam logic [5:0] THRESH    = 6'(CH_NUM);
    localparam logic [4:0] LAST_WORD = 5'(CH_NUM - 1);

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, RD, LATCH, BYTE_HI, BYTE_LO, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, RD, LATCH, BYTE_HI, BYTE_LO, DONE} state_t;
`endif

    state_t      state, next;
    logic        waiting;
    logic        byte_cnt;
    logic [4:0]  word_cnt;
    logic [15:0] word_reg;
    logic        advance;

    // waiting is only set after send_en, so tx_done outside a byte wait is ignored
    assign advance = waiting & tx_done;

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'h00;
        end else if (state == IDLE) begin
            csum <= 8'h00;
        end else if (send_en && (state == BYTE_HI || state == BYTE_LO)) begin
            csum <= csum + tx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            waiting  <= 1'b0;
            byte_cnt <= 1'b0;
            word_cnt <= 5'd0;
            word_reg <= 16'h0000;
        end else begin
            state <= next;
            if (send_en)
                waiting <= 1'b1;
            else if (advance)
                waiting <= 1'b0;
            if (state == HDR && advance)
                byte_cnt <= ~byte_cnt;
            if (state == LATCH)
                word_reg <= ad_data;
            if (state == DONE)
                word_cnt <= 5'd0;
            else if (state == BYTE_LO && advance)
                word_cnt <= word_cnt + 5'd1;
        end
    end

    always_comb begin
        next       = state;
        send_en    = 1'b0;
        rdreq      = 1'b0;
        frame_done = 1'b0;
        busy_tx    = 1'b1;
        tx_data    = 8'h00;
        case (state)
            IDLE: begin
                busy_tx = 1'b0;
                if (rdusedw >= THRESH)
                    next = HDR;
            end
            HDR: begin
                tx_data = byte_cnt ? HDR1 : HDR0;
                send_en = !waiting;
                if (advance && byte_cnt)
                    next = RD;
            end
            RD: begin
                rdreq = 1'b1;
                next  = LATCH;
            end
            LATCH: next = BYTE_HI;
            BYTE_HI: begin
                tx_data = word_reg[15:8];
                send_en = !waiting;
                if (advance)
                    next = BYTE_LO;
            end
            BYTE_LO: begin
                tx_data = word_reg[7:0];
                send_en = !waiting;
                if (advance) begin
`ifdef FRAME_CHECKSUM_EN
                    next = (word_cnt == LAST_WORD) ? CSUM : RD;
`else
                    next = (word_cnt == LAST_WORD) ? DONE : RD;
`endif
                end
            end
`ifdef FRAME_CHECKSUM_EN
            CSUM: begin
                tx_data = csum;
                send_en = !waiting;
                if (advance)
                    next = DONE;
            end
`endif
            DONE: begin
                busy_tx    = 1'b0;
                frame_done = 1'b1;
                next       = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ad7606_frame_tx.sv
// Scoreboard bench for ad7606_frame_tx: FIFO and UART models, expected byte stream
// built from the frame format, monitor compares every send_en byte.
module tb_ad7606_frame_tx;

    localparam int CH = 8;
`ifdef FRAME_CHECKSUM_EN
    localparam int FLEN = 2 + 2*CH + 1;
`else
    localparam int FLEN = 2 + 2*CH;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  rdusedw = 6'd0;
    logic [15:0] ad_data = 16'h0000;
    logic        rdreq, send_en, tx_done, busy_tx, frame_done;
    logic [7:0]  tx_data;
    logic        uart_done = 1'b0;
    logic        spur_done = 1'b0;

    assign tx_done = uart_done | spur_done;

    ad7606_frame_tx #(.CH_NUM(CH)) dut (
        .clk(clk), .rst_n(rst_n), .rdusedw(rdusedw), .ad_data(ad_data),
        .rdreq(rdreq), .tx_data(tx_data), .send_en(send_en), .tx_done(tx_done),
        .busy_tx(busy_tx), .frame_done(frame_done)
    );

    always #10 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int n_send = 0, n_rd = 0, n_fd = 0, frame_bytes = 0, cyc = 0;
    int fall_cyc = -1, last_gap = -1;
    logic [7:0]  last_byte = 8'h00;
    logic [15:0] fifo[$];
    logic [7:0]  exp_q[$];
    bit hold = 0, spur_mode = 0, idle_spur = 0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: header, each word high byte then low byte, optional sum of data bytes
    task automatic expect_frame(input logic [15:0] w [CH]);
        int sum = 0;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        for (int i = 0; i < CH; i++) begin
            exp_q.push_back(8'(w[i] / 256));
            exp_q.push_back(8'(w[i] % 256));
            sum += w[i] / 256 + w[i] % 256;
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
    endtask

    task automatic push_frame(input logic [15:0] w [CH]);
        expect_frame(w);
        for (int i = 0; i < CH; i++) fifo.push_back(w[i]);
    endtask

    task automatic rand_frame();
        logic [15:0] w [CH];
        for (int i = 0; i < CH; i++) w[i] = 16'($urandom);
        push_frame(w);
    endtask

    task automatic wait_fd(input int target, input string name);
        int b = 0;
        while (n_fd < target && b < 4000) begin
            @(negedge clk);
            b++;
        end
        check(name, int'(n_fd >= target), 1);
    endtask

    task automatic wait_bytes(input int target);
        int b = 0;
        while (frame_bytes < target && b < 2000) begin
            @(negedge clk);
            b++;
        end
        check("byte_wait", int'(frame_bytes >= target), 1);
    endtask

    // FIFO model: data appears the cycle after rdreq
    initial forever begin
        @(posedge clk);
        if (rdreq && fifo.size() > 0) ad_data <= fifo.pop_front();
        rdusedw <= (fifo.size() > 63) ? 6'd63 : 6'(fifo.size());
    end

    // UART model: tx_done about 10 cycles after send_en; hold freezes it
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                cnt = 0;
                uart_done <= 1'b0;
            end else begin
                uart_done <= !hold && cnt == 1 && !send_en;
                if (send_en) cnt = 10;
                else if (!hold && cnt != 0) cnt--;
            end
        end
    end

    // Spurious tx_done: in IDLE on request, or coincident with RD / send_en
    initial forever begin
        @(negedge clk);
        spur_done = (spur_mode && (rdreq || send_en)) || idle_spur;
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rdreq) n_rd++;
        if (!rst_n) begin
            frame_bytes = 0;
        end else begin
            if (send_en) begin
                n_send++;
                frame_bytes++;
                last_byte = tx_data;
                if (exp_q.size() == 0) check("unexpected_byte", int'(tx_data), -1);
                else check("byte", int'(tx_data), int'(exp_q.pop_front()));
            end
            if (frame_done) begin
                n_fd++;
                check("frame_len", frame_bytes, FLEN);
                frame_bytes = 0;
            end
        end
        if (!busy_tx && fall_cyc < 0) fall_cyc = cyc;
        if (busy_tx && fall_cyc >= 0) begin
            last_gap = cyc - fall_cyc;
            fall_cyc = -1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w [CH];
        logic [7:0]  snap_data;
        logic        snap_busy;
        int          changes, rd0, snd0;

        // 1: reset with a full scan present
        for (int i = 0; i < CH; i++) fifo.push_back(16'($urandom));
        repeat (6) @(negedge clk);
        check("rst_rdreq_count", n_rd, 0);
        check("rst_busy", int'(busy_tx), 0);
        check("rst_send_en", int'(send_en), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_frame_done", int'(frame_done), 0);
        fifo.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 2: seven words present -> idle; eighth word starts the frame
        for (int i = 0; i < CH; i++) w[i] = 16'(16'h007B + i);
        for (int i = 0; i < CH - 1; i++) fifo.push_back(w[i]);
        repeat (50) @(negedge clk);
        check("below_thresh_send", n_send, 0);
        check("below_thresh_rdreq", n_rd, 0);
        check("below_thresh_busy", int'(busy_tx), 0);
        expect_frame(w);
        fifo.push_back(w[CH-1]);
        wait_fd(1, "frame1_done");
        check("frame1_rdreq", n_rd, CH);
        repeat (5) @(negedge clk);
        check("frame1_done_once", n_fd, 1);

        // 3: checksum pattern
        w[0] = 16'h1234;
        for (int i = 1; i < CH; i++) w[i] = 16'h00FF;
        push_frame(w);
        wait_fd(2, "frame2_done");
`ifdef FRAME_CHECKSUM_EN
        check("checksum_byte", int'(last_byte), 8'h3F);
`else
        check("last_data_byte", int'(last_byte), 8'hFF);
`endif

        // 4: spurious tx_done in IDLE, during RD and with send_en
        snd0 = n_send;
        idle_spur = 1;
        repeat (20) @(negedge clk);
        idle_spur = 0;
        @(negedge clk);
        check("idle_spur_send", n_send - snd0, 0);
        check("idle_spur_busy", int'(busy_tx), 0);
        spur_mode = 1;
        rand_frame();
        wait_fd(3, "spur_frame_done");
        spur_mode = 0;

        // 4b: UART stalls for 500 cycles mid-frame
        rand_frame();
        wait_bytes(3);
        repeat (2) @(negedge clk);
        hold = 1;
        repeat (2) @(negedge clk);
        snap_data = tx_data;
        snap_busy = busy_tx;
        changes = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx_data != snap_data || busy_tx != snap_busy || send_en) changes++;
        end
        check("hold_changes", changes, 0);
        check("hold_busy", int'(snap_busy), 1);
        hold = 0;
        wait_fd(4, "hold_frame_done");

        // 5: two scans queued -> back-to-back frames
        repeat (5) @(negedge clk);
        rd0 = n_rd;
        rand_frame();
        rand_frame();
        wait_fd(6, "b2b_done");
        check("b2b_rdreq", n_rd - rd0, 2*CH);
        check("b2b_gap", last_gap, 2);

        // random frames
        for (int k = 0; k < 3; k++) begin
            rand_frame();
            wait_fd(7 + k, "rand_frame_done");
        end

        // 6: reset during the 5th data byte
        rand_frame();
        wait_bytes(7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_busy", int'(busy_tx), 0);
        check("async_send_en", int'(send_en), 0);
        check("async_tx_data", int'(tx_data), 0);
        check("async_rdreq", int'(rdreq), 0);
        check("async_frame_done", int'(frame_done), 0);
        exp_q.delete();
        fifo.delete();
        rand_frame();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_bytes(1);
        check("restart_first_byte", int'(last_byte), 8'hAA);
        wait_fd(10, "restart_frame_done");

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("fifo_drained", fifo.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
